pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter / next-PC stage directly downstream of the branch comparator.
- Consumes the comparator's jump_condition, plus decoded jump class, immediate and rs1.
- Selects and registers the next PC and drives a valid/ready fetch request to instruction memory.
- Detects misaligned control-flow targets and redirects to a trap vector.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0010, PC loaded on misaligned-target trap

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
jump_condition  input  1  branch-taken flag from comparator
branch_en  input  1  current instruction is conditional branch
jal_en  input  1  current instruction is JAL
jalr_en  input  1  current instruction is JALR
imm  input  32  sign-extended immediate
rs1_value  input  32  rs1 operand (JALR base)
update  input  1  execute stage retires current instruction
stall  input  1  hold PC in EXEC
fetch_ready  input  1  instruction memory accepts request
fetch_valid  output  1  fetch request valid for pc
pc  output  32  current program counter
link_value  output  32  pc+4 (rd value for JAL/JALR)
redirect  output  1  one-cycle pulse: taken control transfer committed
misaligned  output  1  one-cycle pulse: trap taken
trap_pc  output  32  PC of last faulting instruction

Behaviour:
- Clock is clk; reset is asynchronous, active-low (rst_n), one clock domain.
- Reset values: pc=RESET_VECTOR, state=IDLE, fetch_valid=0, redirect=0, misaligned=0, trap_pc=0.
- Reset asserted mid-operation clears everything immediately. No partial update survives.
- States:
  - IDLE: fetch_valid=0; always goes to FETCH next cycle.
  - FETCH: fetch_valid=1. pc stays stable until the handshake. fetch_valid&fetch_ready -> EXEC.
  - EXEC: fetch_valid=0. Waits for update=1 && stall=0, then commits the next PC.
  - TRAP: fetch_valid=0 for one cycle, then FETCH.
- Target selection in EXEC, priority jalr_en > jal_en > branch_en:
  - jalr: (rs1_value+imm) & ~32'h1
  - jal: pc+imm
  - branch with jump_condition=1: pc+imm
  - otherwise (incl. branch not taken): pc+4
- taken = jalr_en | jal_en | (branch_en & jump_condition).
- All arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 = 0x0000_0000, no flag.
- On commit with taken=1 and target[1]=1 (misaligned):
  - trap_pc<=pc, pc<=TRAP_VECTOR, misaligned=1 for one cycle, redirect=0, state->TRAP.
- On commit, normal case:
  - pc<=target; redirect=1 for one cycle iff taken; state->FETCH.
- A non-taken target is never checked for alignment.
- update outside EXEC is ignored. stall outside EXEC is ignored.
- stall=1 in EXEC overrides update; state and pc hold.
- link_value = pc+4, combinational, valid in every state.
- Commit latency: pc updates on the clock edge following update&!stall; next fetch_valid is asserted on that same edge.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - Adds outputs branch_count[31:0] and taken_count[31:0].
  - branch_count increments on every EXEC commit with branch_en=1 and jal_en=jalr_en=0.
  - taken_count increments when such a branch also has jump_condition=1, including misaligned-trap branches.
  - Both counters saturate at 0xFFFF_FFFF and clear on reset.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, fetch_ready=1 -> pc=RESET_VECTOR for IDLE cycle; fetch_valid=1 the next cycle; EXEC after handshake.
- pc=0x100, branch_en=1, jump_condition=1, imm=0x20, update -> pc=0x120, redirect pulse 1 cycle. Same with jump_condition=0 -> pc=0x104, redirect=0.
- jalr_en=1, rs1_value=0x203, imm=0 -> pc=0x202 (bit0 cleared) -> misaligned pulse, trap_pc=old pc, pc=TRAP_VECTOR, fetch_valid low for one TRAP cycle.
- EXEC with stall=1, update=1 for 3 cycles -> pc unchanged; drop stall -> commit next cycle. fetch_ready=0 for 4 cycles in FETCH -> fetch_valid and pc held.
- pc=0xFFFF_FFFC, non-branch update -> pc=0x0000_0000. jal_en and branch_en both set, imm=0x8 -> jal path, redirect=1.
- Assert rst_n=0 mid-FETCH (async, between edges) -> outputs reset immediately. With BRANCH_STATS_EN: 3 branches, 2 taken -> branch_count=3, taken_count=2.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter / next-PC stage: selects the control-flow target, registers the PC,
// issues fetch requests and traps misaligned targets. Optional BRANCH_STATS_EN adds branch counters.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_condition,
    input  logic        branch_en,
    input  logic        jal_en,
    input  logic        jalr_en,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_value,
    input  logic        update,
    input  logic        stall,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] pc,
    output logic [31:0] link_value,
    output logic        redirect,
    output logic        misaligned,
    output logic [31:0] trap_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   pc_next, trap_pc_next, target;
    logic              fetch_valid_next, redirect_next, misaligned_next;
    logic              taken, commit;

    // Target selection: jalr > jal > taken branch > sequential
    always_comb begin
        target = pc + XLEN'(4);
        taken  = jalr_en | jal_en | (branch_en & jump_condition);
        commit = (state == EXEC) && update && !stall;
        if (jalr_en) begin
            target = (rs1_value + imm) & ~XLEN'(1);
        end else if (jal_en || (branch_en && jump_condition)) begin
            target = pc + imm;
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        trap_pc_next     = trap_pc;
        redirect_next    = 1'b0;
        misaligned_next  = 1'b0;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: if (fetch_ready) state_next = EXEC;
            EXEC: begin
                if (commit) begin
                    if (taken && target[1]) begin
                        trap_pc_next    = pc;
                        pc_next         = TRAP_VECTOR;
                        misaligned_next = 1'b1;
                        state_next      = TRAP;
                    end else begin
                        pc_next       = target;
                        redirect_next = taken;
                        state_next    = FETCH;
                    end
                end
            end
            TRAP:    state_next = FETCH;
            default: state_next = IDLE;
        endcase
        fetch_valid_next = (state_next == FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            trap_pc     <= '0;
            fetch_valid <= 1'b0;
            redirect    <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            trap_pc     <= trap_pc_next;
            fetch_valid <= fetch_valid_next;
            redirect    <= redirect_next;
            misaligned  <= misaligned_next;
        end
    end

    assign link_value = pc + XLEN'(4);

`ifdef BRANCH_STATS_EN
    logic is_branch;
    assign is_branch = commit && branch_en && !jal_en && !jalr_en;

    // Saturating branch statistics; trapped branches still count as taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (is_branch) begin
            if (branch_count != '1) branch_count <= branch_count + XLEN'(1);
            if (jump_condition && (taken_count != '1)) taken_count <= taken_count + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: transaction-level reference model, directed scenarios
// and randomized stimulus. Counter checks are active when BRANCH_STATS_EN is defined.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_condition, branch_en, jal_en, jalr_en;
    logic [31:0] imm, rs1_value;
    logic        update, stall, fetch_ready;
    logic        fetch_valid, redirect, misaligned;
    logic [31:0] pc, link_value, trap_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count, taken_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: 0=waiting to fetch, 1=fetch requested, 2=executing, 3=trap bubble
    int          m_phase;
    logic [31:0] m_pc, m_trap_pc;
    logic        m_redirect, m_mis;
    longint      m_bcnt, m_tcnt;

    pc_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst_n(rst_n), .jump_condition(jump_condition), .branch_en(branch_en),
        .jal_en(jal_en), .jalr_en(jalr_en), .imm(imm), .rs1_value(rs1_value),
        .update(update), .stall(stall), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc(pc), .link_value(link_value), .redirect(redirect),
        .misaligned(misaligned), .trap_pc(trap_pc)
`ifdef BRANCH_STATS_EN
        , .branch_count(branch_count), .taken_count(taken_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pc = RV; m_trap_pc = 0; m_redirect = 0; m_mis = 0;
        m_bcnt = 0; m_tcnt = 0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit tk;
        m_redirect = 0;
        m_mis = 0;
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 3) m_phase = 1;
        else if (m_phase == 1) begin
            if (fetch_ready) m_phase = 2;
        end else if (update && !stall) begin
            tk = jalr_en || jal_en || (branch_en && jump_condition);
            if (jalr_en)  tgt = (rs1_value + imm) & 32'hFFFF_FFFE;
            else if (tk)  tgt = m_pc + imm;
            else          tgt = m_pc + 32'd4;
            if (branch_en && !jal_en && !jalr_en) begin
                if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
                if (jump_condition && m_tcnt < 64'hFFFF_FFFF) m_tcnt++;
            end
            if (tk && tgt[1]) begin
                m_trap_pc = m_pc; m_pc = TV; m_mis = 1; m_phase = 3;
            end else begin
                m_pc = tgt; m_redirect = tk; m_phase = 1;
            end
        end
    endtask

    task automatic compare();
        check("pc", pc, m_pc);
        check("fetch_valid", 32'(fetch_valid), 32'(m_phase == 1));
        check("redirect", 32'(redirect), 32'(m_redirect));
        check("misaligned", 32'(misaligned), 32'(m_mis));
        check("trap_pc", trap_pc, m_trap_pc);
        check("link_value", link_value, m_pc + 32'd4);
`ifdef BRANCH_STATS_EN
        check("branch_count", branch_count, 32'(m_bcnt));
        check("taken_count", taken_count, 32'(m_tcnt));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_ctl();
        jump_condition = 0; branch_en = 0; jal_en = 0; jalr_en = 0;
        imm = 0; rs1_value = 0; update = 0; stall = 0;
    endtask

    task automatic go_exec();
        clear_ctl();
        fetch_ready = 1;
        for (int i = 0; i < 8 && m_phase != 2; i++) tick();
        check("reach_exec", 32'(m_phase == 2 && !fetch_valid), 32'd1);
    endtask

    task automatic commit(input logic jr, input logic j, input logic br, input logic cond,
                          input logic [31:0] im, input logic [31:0] r1);
        jalr_en = jr; jal_en = j; branch_en = br; jump_condition = cond;
        imm = im; rs1_value = r1; update = 1; stall = 0;
        tick();
        clear_ctl();
    endtask

    task automatic set_pc(input logic [31:0] v);
        go_exec();
        commit(1, 0, 0, 0, 32'd0, v);
    endtask

    logic [31:0] held;

    initial begin
        rst_n = 0; fetch_ready = 1;
        clear_ctl();
        model_reset();
        @(negedge clk);
        compare();
        check("rst_pc", pc, 32'h0);
        check("rst_fv", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        rst_n = 1;
        compare();
        tick();
        check("fv_after_idle", 32'(fetch_valid), 32'd1);
        tick();
        check("exec_after_hs", 32'(fetch_valid), 32'd0);

        // taken and not-taken branch from 0x100
        set_pc(32'h100);
        check("pc_0x100", pc, 32'h100);
        go_exec();
        commit(0, 0, 1, 1, 32'h20, 32'h0);
        check("br_taken_pc", pc, 32'h120);
        check("br_taken_redirect", 32'(redirect), 32'd1);
        go_exec();
        check("redirect_one_cycle", 32'(redirect), 32'd0);
        set_pc(32'h100);
        go_exec();
        commit(0, 0, 1, 0, 32'h20, 32'h0);
        check("br_nt_pc", pc, 32'h104);
        check("br_nt_redirect", 32'(redirect), 32'd0);

        // misaligned jalr target traps
        go_exec();
        commit(1, 0, 0, 0, 32'h0, 32'h203);
        check("trap_mis", 32'(misaligned), 32'd1);
        check("trap_pc_val", trap_pc, 32'h104);
        check("trap_vec", pc, 32'h10);
        check("trap_fv", 32'(fetch_valid), 32'd0);
        check("trap_redirect", 32'(redirect), 32'd0);
        tick();
        check("post_trap_fv", 32'(fetch_valid), 32'd1);
        check("post_trap_mis", 32'(misaligned), 32'd0);

        // stall overrides update
        go_exec();
        held = pc;
        update = 1; stall = 1; jal_en = 1; imm = 32'h40;
        for (int i = 0; i < 3; i++) tick();
        check("stall_pc", pc, held);
        stall = 0; jal_en = 0;
        tick();
        clear_ctl();
        check("unstall_pc", pc, held + 32'd4);

        // fetch_ready low holds the request
        fetch_ready = 0;
        held = pc;
        for (int i = 0; i < 4; i++) tick();
        check("hold_fv", 32'(fetch_valid), 32'd1);
        check("hold_pc", pc, held);

        // wraparound and jal priority over branch
        set_pc(32'hFFFF_FFFC);
        go_exec();
        commit(0, 0, 0, 0, 32'h0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        go_exec();
        commit(0, 1, 1, 0, 32'h8, 32'h0);
        check("jal_prio_pc", pc, 32'h8);
        check("jal_prio_redirect", 32'(redirect), 32'd1);

`ifdef BRANCH_STATS_EN
        begin
            logic [31:0] b0, t0;
            b0 = branch_count; t0 = taken_count;
            go_exec(); commit(0, 0, 1, 1, 32'h10, 32'h0);
            go_exec(); commit(0, 0, 1, 0, 32'h10, 32'h0);
            go_exec(); commit(0, 0, 1, 1, 32'h10, 32'h0);
            check("stat_branch", branch_count - b0, 32'd3);
            check("stat_taken", taken_count - t0, 32'd2);
        end
`endif

        // async reset mid-FETCH, between clock edges
        fetch_ready = 0;
        #3 rst_n = 0;
        #1;
        model_reset();
        compare();
        check("async_pc", pc, RV);
        check("async_fv", 32'(fetch_valid), 32'd0);
        check("async_redirect", 32'(redirect), 32'd0);
        @(negedge clk);
        compare();
        rst_n = 1;

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            fetch_ready    = ($urandom_range(0, 9) < 7);
            update         = $urandom_range(0, 1);
            stall          = ($urandom_range(0, 3) == 0);
            jalr_en        = ($urandom_range(0, 5) == 0);
            jal_en         = ($urandom_range(0, 4) == 0);
            branch_en      = $urandom_range(0, 1);
            jump_condition = $urandom_range(0, 1);
            imm            = $urandom;
            rs1_value      = $urandom;
            if ($urandom_range(0, 1) == 1) imm = imm & 32'h0000_0FFC;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
